// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: opcodes, ALU ops, the decoded bundle and the stage FSM states.
package decode_stage_pkg;

  // The bundle is sized for the widest datapath; narrower instances use the low XLEN bits.
  localparam int XLEN_MAX = 64;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef logic [XLEN_MAX-1:0] imm_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {DS_EMPTY, DS_FULL, DS_SKID} ds_state_t;

  typedef struct packed {
    imm_t       pc;
    opcode_t    opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    imm_t       imm;
    alu_op_t    alu_control;
    logic       is_m;
    logic       illegal;
  } decode_bundle_t;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/decode_stage_alu_decoder.sv
// ALU operation select from opcode/funct3/funct7[5]; anything without an ALU role defaults to ADD.
module decode_stage_alu_decoder
  import decode_stage_pkg::*;
(
  input  opcode_t    opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_control
);

  // Register/immediate ops share the funct3 map; only register ops use funct7[5] to pick SUB.
  always_comb begin
    alu_control = ALU_ADD;
    if (opcode == OP_REG || opcode == OP_IMM) begin
      case (funct3)
        3'b000:  alu_control = (opcode == OP_REG && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b011:  alu_control = ALU_SLTU;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end else if (opcode == OP_BRANCH) begin
      case (funct3[2:1])
        2'b10:   alu_control = ALU_SLT;
        2'b11:   alu_control = ALU_SLTU;
        default: alu_control = ALU_SUB;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage_decode_comb.sv
// Purely combinational instruction decoder: raw word + PC -> decode_bundle_t.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int EN_M_EXT = 0,
  parameter int EN_TRAP  = 1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decode_bundle_t  dec
);

  opcode_t    opc;
  logic [2:0] f3;
  logic [6:0] f7, sh_f7;
  logic       is_r, is_i, is_s, is_b, is_u, is_j, known;
  logic       r_bad, i_bad, illegal, is_m;
  alu_op_t    alu_raw;

  decode_stage_alu_decoder u_alu_dec (
    .opcode      (opc),
    .funct3      (f3),
    .funct7_5    (instr[30]),
    .alu_control (alu_raw)
  );

  // Format classification and legality checks.
  always_comb begin
    opc   = opcode_t'(instr[6:0]);
    f3    = instr[14:12];
    f7    = instr[31:25];
    is_r  = (opc == OP_REG);
    is_i  = (opc == OP_IMM) || (opc == OP_LOAD) || (opc == OP_JALR);
    is_s  = (opc == OP_STORE);
    is_b  = (opc == OP_BRANCH);
    is_u  = (opc == OP_LUI) || (opc == OP_AUIPC);
    is_j  = (opc == OP_JAL);
    known = is_r | is_i | is_s | is_b | is_u | is_j;
    // RV64 shifts carry a 6-bit shamt, so instr[25] belongs to the shift amount there.
    sh_f7 = (XLEN == 64) ? {instr[31:26], 1'b0} : instr[31:25];
    r_bad = is_r && !((f7 == F7_ZERO) || (f7 == F7_ALT) || (EN_M_EXT != 0 && f7 == F7_MULDIV));
    r_bad = r_bad || (is_r && f7 == F7_ALT && !(f3 == 3'b000 || f3 == 3'b101));
    i_bad = (opc == OP_IMM) && (f3 == 3'b001 || f3 == 3'b101) &&
            !(sh_f7 == F7_ZERO || sh_f7 == F7_ALT);
    illegal = (EN_TRAP != 0) && ((instr[1:0] != 2'b11) || !known || r_bad || i_bad);
    is_m    = (EN_M_EXT != 0) && is_r && (f7 == F7_MULDIV);
  end

  // Field extraction; an illegal word keeps opcode/funct but zeroes registers, immediate and ALU op.
  always_comb begin
    dec        = '0;
    dec.pc     = imm_t'(pc);
    dec.opcode = opc;
    dec.funct3 = (is_r | is_i | is_s | is_b) ? f3 : 3'b000;
    dec.funct7 = (is_r | (opc == OP_IMM)) ? f7 : 7'b0000000;
    dec.is_m   = is_m & ~illegal;
    dec.illegal = illegal;
    if (!illegal) begin
      dec.rd  = (is_r | is_i | is_u | is_j) ? instr[11:7]  : 5'd0;
      dec.rs1 = (is_r | is_i | is_s | is_b) ? instr[19:15] : 5'd0;
      dec.rs2 = (is_r | is_s | is_b)        ? instr[24:20] : 5'd0;
      if (is_i)      dec.imm = {{52{instr[31]}}, instr[31:20]};
      else if (is_s) dec.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      else if (is_b) dec.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      else if (is_j) dec.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      else if (is_u) dec.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      dec.alu_control = is_m ? ALU_ADD : alu_raw;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder, output register and 1-entry skid buffer under valid/ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int EN_M_EXT = 0,
  parameter int EN_TRAP  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm_ext,
  output logic [3:0]      out_alu_control,
  output logic            out_is_m,
  output logic            out_illegal
);

  ds_state_t      state;
  decode_bundle_t dec, out_q, skid_q;
  logic           accept;
  logic           unused_hi;

  decode_comb #(.XLEN(XLEN), .EN_M_EXT(EN_M_EXT), .EN_TRAP(EN_TRAP)) u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  assign accept = in_valid & in_ready & ~flush;

  // Handshake FSM; in_ready and out_valid are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DS_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= DS_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        DS_EMPTY: if (accept) begin
          out_q     <= dec;
          out_valid <= 1'b1;
          state     <= DS_FULL;
        end
        DS_FULL: begin
          if (accept && !out_ready) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
            state    <= DS_SKID;
          end else if (accept) begin
            out_q <= dec;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DS_EMPTY;
          end
        end
        DS_SKID: if (out_ready) begin
          out_q    <= skid_q;
          in_ready <= 1'b1;
          state    <= DS_FULL;
        end
        default: begin
          state     <= DS_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_pc          = out_q.pc[XLEN-1:0];
  assign out_opcode      = out_q.opcode;
  assign out_funct3      = out_q.funct3;
  assign out_funct7      = out_q.funct7;
  assign out_rd          = out_q.rd;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_imm_ext     = out_q.imm[XLEN-1:0];
  assign out_alu_control = out_q.alu_control;
  assign out_is_m        = out_q.is_m;
  assign out_illegal     = out_q.illegal;
  // Upper bundle bits above XLEN are intentionally dropped on narrow instances.
  assign unused_hi       = ^{out_q.pc, out_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: a 32-bit base instance and a 64-bit M-extension instance driven in lockstep.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc32;
  logic [63:0] in_pc64;

  logic        a_in_ready, a_out_valid, a_is_m, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [3:0]  a_alu;

  logic        b_in_ready, b_out_valid, b_is_m, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [3:0]  b_alu;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_M_EXT(0), .EN_TRAP(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opcode), .out_funct3(a_funct3), .out_funct7(a_funct7),
    .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm_ext(a_imm),
    .out_alu_control(a_alu), .out_is_m(a_is_m), .out_illegal(a_illegal)
  );

  decode_stage #(.XLEN(64), .EN_M_EXT(1), .EN_TRAP(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opcode), .out_funct3(b_funct3), .out_funct7(b_funct7),
    .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm_ext(b_imm),
    .out_alu_control(b_alu), .out_is_m(b_is_m), .out_illegal(b_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc32  = pc;
    in_pc64  = {32'h0, pc};
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_imm", b_imm, 0);
    step(); step();
    reset = 1'b0;

    // addi x1,x2,-1
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF10093, 32'h100);
    step();
    chk("t1_valid", a_out_valid, 1);
    chk("t1_rd", a_rd, 1);
    chk("t1_rs1", a_rs1, 2);
    chk("t1_imm", a_imm, 32'hFFFFFFFF);
    chk("t1_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("t1_illegal", a_illegal, 0);
    chk("t1_pc", a_pc, 32'h100);
    chk("t1_opcode", a_opcode, 7'h13);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("t1_drain", a_out_valid, 0);

    // back-pressure: A, B accepted, C stalled, then released in order
    out_ready = 1'b0;
    drive(1'b1, 32'h00500293, 32'h200);       // addi x5,x0,5
    step();
    chk("t2_a_valid", a_out_valid, 1);
    chk("t2_a_ready", a_in_ready, 1);
    drive(1'b1, 32'h00528333, 32'h204);       // add x6,x5,x5
    step();
    chk("t2_skid_ready", a_in_ready, 0);
    chk("t2_hold_pc", a_pc, 32'h200);
    drive(1'b1, 32'h405303B3, 32'h208);       // sub x7,x6,x5
    step();
    chk("t2_stall_ready", a_in_ready, 0);
    chk("t2_stall_pc", a_pc, 32'h200);
    chk("t2_stall_imm", a_imm, 32'h5);
    out_ready = 1'b1;
    step();
    chk("t2_b_pc", a_pc, 32'h204);
    chk("t2_b_rd", a_rd, 6);
    chk("t2_b_alu", a_alu, 0);
    chk("t2_b_ready", a_in_ready, 1);
    step();
    chk("t2_c_pc", a_pc, 32'h208);
    chk("t2_c_rd", a_rd, 7);
    chk("t2_c_alu", a_alu, 1);
    chk("t2_c_funct7", a_funct7, 7'h20);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("t2_empty", a_out_valid, 0);

    // flush while SKID with an incoming instruction
    out_ready = 1'b0;
    drive(1'b1, 32'h00500293, 32'h300);
    step();
    drive(1'b1, 32'h00528333, 32'h304);
    step();
    chk("t3_skid", a_in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'h405303B3, 32'h308);
    step();
    chk("t3_flush_valid", a_out_valid, 0);
    chk("t3_flush_ready", a_in_ready, 1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("t3_no_ghost1", a_out_valid, 0);
    step();
    chk("t3_no_ghost2", b_out_valid, 0);

    // illegal and M-extension encodings
    drive(1'b1, 32'h00000000, 32'h400);
    step();
    chk("t4_zero_ill", a_illegal, 1);
    chk("t4_zero_valid", a_out_valid, 1);
    chk("t4_zero_regs", {a_rd, a_rs1, a_rs2}, 0);
    drive(1'b1, 32'h022081B3, 32'h404);       // mul x3,x1,x2
    step();
    chk("t4_mul_ill_nom", a_illegal, 1);
    chk("t4_mul_rd_nom", a_rd, 0);
    chk("t4_mul_ism_nom", a_is_m, 0);
    chk("t4_mul_ill_m", b_illegal, 0);
    chk("t4_mul_ism_m", b_is_m, 1);
    chk("t4_mul_regs_m", {b_rd, b_rs1, b_rs2}, {5'd3, 5'd1, 5'd2});
    chk("t4_mul_alu_m", b_alu, 0);
    drive(1'b1, 32'h800000B7, 32'h408);       // lui x1,0x80000
    step();
    chk("t5_lui_imm64", b_imm, 64'hFFFFFFFF80000000);
    chk("t5_lui_rd", b_rd, 1);
    chk("t5_lui_imm32", a_imm, 32'h80000000);
    chk("t5_lui_pc64", b_pc, 64'h408);
    drive(1'b1, 32'h40315093, 32'h40C);       // srai x1,x2,3
    step();
    chk("srai_alu", a_alu, 7);
    chk("srai_ill", a_illegal, 0);
    drive(1'b1, 32'h02111093, 32'h410);       // slli with funct7=0000001
    step();
    chk("slli_bad32", a_illegal, 1);
    chk("slli_ok64", b_illegal, 0);
    chk("slli_alu64", b_alu, 2);
    drive(1'b1, 32'hFE512E23, 32'h414);       // sw x5,-4(x2)
    step();
    chk("sw_imm", a_imm, 32'hFFFFFFFC);
    chk("sw_regs", {a_rd, a_rs1, a_rs2}, {5'd0, 5'd2, 5'd5});
    chk("sw_funct3", a_funct3, 3'b010);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // asynchronous reset while FULL and stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h00500293, 32'h500);
    step();
    chk("t6_full", a_out_valid, 1);
    drive(1'b0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", a_out_valid, 0);
    chk("t6_async_ready", a_in_ready, 1);
    chk("t6_async_pc", a_pc, 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t6_after1", a_out_valid, 0);
    step();
    chk("t6_after2", b_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
